// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clk_en_gen_multi divider channels: state encoding,
// default ratio width and the ratio normalisation helper.
package clk_gen_pkg;

    localparam int DIV_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        STOPPING = 2'b10
    } ch_state_t;

    // A programmed ratio of 0 behaves as divide-by-1.
    function automatic logic [31:0] norm_ratio(input logic [31:0] r);
        return (r == 32'd0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/clk_en_div_ch.sv
// One divide-by-R clock-enable channel: counter, run FSM, shadow ratio and
// optional 16-bit tick statistic (enabled by CLK_EN_GEN_STAT_EN).
module clk_en_div_ch
    import clk_gen_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ch_en,
    input  logic [DIV_WIDTH-1:0] ratio,
    input  logic                 load,
    input  logic                 restart,
    output logic                 pending_next,
    output logic                 tick_o,
    output logic                 half_o,
    output logic                 run_o,
    output logic [15:0]          tick_cnt_o
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    ch_state_t            state_reg, state_next;
    logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
    logic [DIV_WIDTH-1:0] act_reg, act_next;
    logic [DIV_WIDTH-1:0] shadow_reg, shadow_next;
    logic                 pending_reg;
    logic                 tick_reg, half_reg, run_reg;
    logic                 run_next, tick_next, half_next, wrap;

    assign wrap = (cnt_reg == act_reg - ONE);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        act_next     = act_reg;
        shadow_next  = shadow_reg;
        pending_next = pending_reg;
        if (load) begin
            shadow_next  = ratio;
            pending_next = 1'b1;
        end
        if (restart) begin
            // Realignment: new ratios apply immediately, truncated period gives no tick.
            if (load)
                act_next = DIV_WIDTH'(norm_ratio(32'(ratio)));
            else if (pending_reg)
                act_next = DIV_WIDTH'(norm_ratio(32'(shadow_reg)));
            pending_next = 1'b0;
            cnt_next     = '0;
            case (state_reg)
                IDLE:    state_next = ch_en ? RUN : IDLE;
                RUN:     state_next = ch_en ? RUN : STOPPING;
                default: state_next = IDLE;
            endcase
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next = '0;
                    if (pending_reg) begin
                        act_next     = DIV_WIDTH'(norm_ratio(32'(shadow_reg)));
                        pending_next = load;
                    end
                    if (ch_en)
                        state_next = RUN;
                end
                default: begin
                    if (wrap) begin
                        cnt_next = '0;
                        if (pending_reg) begin
                            act_next     = DIV_WIDTH'(norm_ratio(32'(shadow_reg)));
                            pending_next = load;
                        end
                        if (ch_en)
                            state_next = RUN;
                        else
                            state_next = (state_reg == STOPPING) ? IDLE : STOPPING;
                    end else begin
                        cnt_next   = cnt_reg + ONE;
                        state_next = ch_en ? RUN : STOPPING;
                    end
                end
            endcase
        end
    end

    // Outputs are registered from the next-state view so they line up with cnt.
    assign run_next  = (state_next != IDLE);
    assign tick_next = run_next && (cnt_next == act_next - ONE);
    assign half_next = run_next && (cnt_next < (act_next >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            act_reg     <= ONE;
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
            tick_reg    <= 1'b0;
            half_reg    <= 1'b0;
            run_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            act_reg     <= act_next;
            shadow_reg  <= shadow_next;
            pending_reg <= pending_next;
            tick_reg    <= tick_next;
            half_reg    <= half_next;
            run_reg     <= run_next;
        end
    end

    assign tick_o = tick_reg;
    assign half_o = half_reg;
    assign run_o  = run_reg;

`ifdef CLK_EN_GEN_STAT_EN
    logic [15:0] stat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat_reg <= '0;
        else if (tick_reg)
            stat_reg <= stat_reg + 16'd1;
    end

    assign tick_cnt_o = stat_reg;
`else
    assign tick_cnt_o = '0;
`endif

endmodule

// File: rtl/clk_en_gen_multi.sv
// CH_NUM programmable clock-enable channels sharing one staged-config handshake
// and a global realign pulse. Define CLK_EN_GEN_STAT_EN for per-channel tick counts.
module clk_en_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int CH_NUM    = 4,
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CH_NUM-1:0]           ch_en,
    input  logic [CH_NUM*DIV_WIDTH-1:0] div_ratio,
    input  logic                        cfg_load,
    output logic                        cfg_busy,
    output logic                        cfg_err,
    input  logic                        sync_restart,
    output logic [CH_NUM-1:0]           tick_o,
    output logic [CH_NUM-1:0]           half_o,
    output logic [CH_NUM-1:0]           run_o,
    output logic [CH_NUM*16-1:0]        tick_cnt_o
);

    logic              cfg_busy_reg, cfg_err_reg;
    logic              capture;
    logic [CH_NUM-1:0] pend_next;

    // A realign pulse makes a load safe even while busy, since everything applies at once.
    assign capture = cfg_load && (!cfg_busy_reg || sync_restart);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_busy_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            cfg_busy_reg <= |pend_next;
            cfg_err_reg  <= cfg_load && cfg_busy_reg && !sync_restart;
        end
    end

    assign cfg_busy = cfg_busy_reg;
    assign cfg_err  = cfg_err_reg;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            clk_en_div_ch #(
                .DIV_WIDTH(DIV_WIDTH)
            ) u_ch (
                .clk          (clk),
                .rst_n        (rst_n),
                .ch_en        (ch_en[gi]),
                .ratio        (div_ratio[gi*DIV_WIDTH +: DIV_WIDTH]),
                .load         (capture),
                .restart      (sync_restart),
                .pending_next (pend_next[gi]),
                .tick_o       (tick_o[gi]),
                .half_o       (half_o[gi]),
                .run_o        (run_o[gi]),
                .tick_cnt_o   (tick_cnt_o[gi*16 +: 16])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_en_gen_multi.sv
// Directed self-checking bench for clk_en_gen_multi (CH_NUM=4, DIV_WIDTH=8).
module tb_clk_en_gen_multi;

    localparam int CH_NUM    = 4;
    localparam int DIV_WIDTH = 8;

    logic                        clk;
    logic                        rst_n;
    logic [CH_NUM-1:0]           ch_en;
    logic [CH_NUM*DIV_WIDTH-1:0] div_ratio;
    logic                        cfg_load;
    logic                        cfg_busy;
    logic                        cfg_err;
    logic                        sync_restart;
    logic [CH_NUM-1:0]           tick_o;
    logic [CH_NUM-1:0]           half_o;
    logic [CH_NUM-1:0]           run_o;
    logic [CH_NUM*16-1:0]        tick_cnt_o;

    int total = 0;
    int bad   = 0;

    clk_en_gen_multi #(
        .CH_NUM    (CH_NUM),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .div_ratio    (div_ratio),
        .cfg_load     (cfg_load),
        .cfg_busy     (cfg_busy),
        .cfg_err      (cfg_err),
        .sync_restart (sync_restart),
        .tick_o       (tick_o),
        .half_o       (half_o),
        .run_o        (run_o),
        .tick_cnt_o   (tick_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        ch_en        = '0;
        div_ratio    = '0;
        cfg_load     = 1'b0;
        sync_restart = 1'b0;
        repeat (3) step();
        chk("rst_tick", 64'(tick_o), 64'(0));
        chk("rst_half", 64'(half_o), 64'(0));
        chk("rst_run", 64'(run_o), 64'(0));
        chk("rst_busy", 64'(cfg_busy), 64'(0));
        chk("rst_err", 64'(cfg_err), 64'(0));
        chk("rst_cnt", 64'(tick_cnt_o), 64'(0));
        rst_n = 1'b1;
        step();
        chk("idle_run", 64'(run_o), 64'(0));

        // Program ratios ch3..ch0 = 7,0,3,4 while all channels idle.
        div_ratio = {8'd7, 8'd0, 8'd3, 8'd4};
        cfg_load  = 1'b1;
        step();
        cfg_load = 1'b0;
        chk("cfg_busy_set", 64'(cfg_busy), 64'(1));
        chk("cfg_err_none", 64'(cfg_err), 64'(0));
        step();
        chk("cfg_busy_idle_clr", 64'(cfg_busy), 64'(0));

        // Channel 0, R=4: ticks in cycles 4,8,12; half in cycles 1-2, 5-6, 9-10.
        ch_en = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk($sformatf("t1_tick_c%0d", c), 64'(tick_o[0]), 64'(c % 4 == 0));
            chk($sformatf("t1_half_c%0d", c), 64'(half_o[0]), 64'((c % 4 == 1) || (c % 4 == 2)));
            chk($sformatf("t1_run_c%0d", c), 64'(run_o[0]), 64'(1));
        end
        // Drop at the wrap edge: one more full period, then idle.
        ch_en = 4'b0000;
        for (int c = 13; c <= 17; c++) begin
            step();
            chk($sformatf("t1s_tick_c%0d", c), 64'(tick_o[0]), 64'(c == 16));
            chk($sformatf("t1s_run_c%0d", c), 64'(run_o[0]), 64'(c != 17));
        end

        // Channel 2 programmed with ratio 0 behaves as R=1.
        ch_en = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("t5_tick_c%0d", c), 64'(tick_o[2]), 64'(1));
            chk($sformatf("t5_half_c%0d", c), 64'(half_o[2]), 64'(0));
            chk($sformatf("t5_run_c%0d", c), 64'(run_o[2]), 64'(1));
        end
        ch_en = 4'b0000;
        step();
        chk("t5_final_tick", 64'(tick_o[2]), 64'(1));
        step();
        chk("t5_stop_run", 64'(run_o[2]), 64'(0));
        chk("t5_stop_tick", 64'(tick_o[2]), 64'(0));

        // Channel 1, R=3, switched to 5 via a load sampled at cnt=0.
        ch_en = 4'b0010;
        step();
        chk("t2_c1_half", 64'(half_o[1]), 64'(1));
        step();
        chk("t2_c2_half", 64'(half_o[1]), 64'(0));
        step();
        chk("t2_c3_tick", 64'(tick_o[1]), 64'(1));
        step();
        chk("t2_c4_tick", 64'(tick_o[1]), 64'(0));
        div_ratio = {8'd7, 8'd0, 8'd5, 8'd4};
        cfg_load  = 1'b1;
        step();
        chk("t2_c5_busy", 64'(cfg_busy), 64'(1));
        chk("t2_c5_err", 64'(cfg_err), 64'(0));
        chk("t2_c5_tick", 64'(tick_o[1]), 64'(0));
        // Second load while busy must be rejected (ratio 9 never used).
        div_ratio = {8'd7, 8'd0, 8'd9, 8'd4};
        step();
        cfg_load  = 1'b0;
        div_ratio = {8'd7, 8'd0, 8'd5, 8'd4};
        chk("t2_c6_err", 64'(cfg_err), 64'(1));
        chk("t2_c6_busy", 64'(cfg_busy), 64'(1));
        chk("t2_c6_tick", 64'(tick_o[1]), 64'(1));
        for (int c = 7; c <= 12; c++) begin
            step();
            if (c == 7) begin
                chk("t2_c7_err", 64'(cfg_err), 64'(0));
                chk("t2_c7_busy", 64'(cfg_busy), 64'(0));
            end
            chk($sformatf("t2_tick_c%0d", c), 64'(tick_o[1]), 64'(c == 11));
            chk($sformatf("t2_half_c%0d", c), 64'(half_o[1]), 64'((c == 7) || (c == 8) || (c == 12)));
        end

        // Start ch0 and ch3, then load + realign mid-period to R = 2, 3, 7.
        ch_en = 4'b1011;
        step();
        step();
        div_ratio    = {8'd7, 8'd0, 8'd3, 8'd2};
        cfg_load     = 1'b1;
        sync_restart = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            cfg_load     = 1'b0;
            sync_restart = 1'b0;
            if (k == 1) begin
                chk("t4_busy", 64'(cfg_busy), 64'(0));
                chk("t4_err", 64'(cfg_err), 64'(0));
            end
            chk($sformatf("t4_tick_k%0d", k), 64'(tick_o),
                64'({k % 7 == 0, 1'b0, k % 3 == 0, k % 2 == 0}));
            chk($sformatf("t4_half_k%0d", k), 64'(half_o),
                64'({(k - 1) % 7 < 3, 1'b0, k % 3 == 1, k % 2 == 1}));
        end

        // Realign with ch3 at R=6; drop its enable at cnt=2.
        div_ratio    = {8'd6, 8'd0, 8'd3, 8'd2};
        cfg_load     = 1'b1;
        sync_restart = 1'b1;
        step();
        cfg_load     = 1'b0;
        sync_restart = 1'b0;
        chk("t3_start_tick", 64'(tick_o[3]), 64'(0));
        chk("t3_start_run", 64'(run_o[3]), 64'(1));
        step();
        step();
        ch_en = 4'b0011;
        for (int j = 4; j <= 10; j++) begin
            step();
            chk($sformatf("t3_tick_j%0d", j), 64'(tick_o[3]), 64'(j == 6));
            chk($sformatf("t3_run_j%0d", j), 64'(run_o[3]), 64'(j <= 6));
        end

`ifndef CLK_EN_GEN_STAT_EN
        chk("stat_off_zero", 64'(tick_cnt_o), 64'(0));
`endif

        // Asynchronous reset in the middle of activity.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_run", 64'(run_o), 64'(0));
        chk("mid_rst_tick", 64'(tick_o), 64'(0));
        chk("mid_rst_half", 64'(half_o), 64'(0));
        step();
        chk("mid_rst_hold", 64'(run_o), 64'(0));
        ch_en = 4'b0000;
        rst_n = 1'b1;
        step();
        chk("post_rst_run", 64'(run_o), 64'(0));
        chk("post_rst_cnt", 64'(tick_cnt_o), 64'(0));

`ifdef CLK_EN_GEN_STAT_EN
        // Reset ratio is 1: 70000 consecutive ticks wrap the 16-bit counter to 4464.
        ch_en = 4'b0001;
        repeat (70001) step();
        chk("t6_stat_wrap", 64'(tick_cnt_o[15:0]), 64'(16'd4464));
        chk("t6_stat_others", 64'(tick_cnt_o[63:16]), 64'(0));
        ch_en = 4'b0000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
